// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/phase types and width defaults for the VeriRISC sequencer
package cpu_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;
    typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
    } phase_t;
endpackage

// File: rtl/ctl_decode.sv
// ctl_decode: combinational map from (phase, opcode, zero, halt) to the control strobe set
module ctl_decode
    import cpu_pkg::*;
(
    input  phase_t  phase,
    input  opcode_t op,
    input  logic    zero,
    input  logic    halt,
    output logic    mem_read,
    output logic    mem_write,
    output logic    ld_ac,
    output logic    data_e,
    output logic    ld_ir,
    output logic    inc_pc,
    output logic    ld_pc,
    output logic    set_halt
);
    logic aluop, run, late;
    always_comb begin
        aluop     = op inside {ADD, AND, XOR, LDA};
        run       = !halt;
        late      = phase inside {ALU_OP, STORE};
        mem_read  = run && (phase inside {INST_FETCH, INST_LOAD, IDLE} ||
                            (aluop && phase inside {OP_FETCH, ALU_OP, STORE}));
        mem_write = run && op == STO && phase == STORE;
        ld_ac     = run && aluop && phase == STORE;
        data_e    = run && op == STO && late;
        ld_ir     = run && phase inside {INST_LOAD, IDLE};
        // SKZ skips by taking a second increment after the normal one
        inc_pc    = run && ((phase == OP_ADDR && op != HLT) ||
                            (phase == ALU_OP && op == SKZ && zero));
        ld_pc     = run && op == JMP && late;
        set_halt  = run && op == HLT && phase == OP_ADDR;
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: VeriRISC fetch/execute sequencer holding phase, PC, IR and halt state
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [DW-1:0] mem_data_out,
    input  logic          zero,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic          ld_ac,
    output logic          data_e,
    output logic [2:0]    opcode,
    output logic [AW-1:0] pc,
    output logic          halt
);
    phase_t        phase_q, phase_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          halt_q, halt_d;
    logic          ld_ir, inc_pc, ld_pc, set_halt;

    ctl_decode u_dec (
        .phase    (phase_q),
        .op       (opcode_t'(ir_q[DW-1:DW-3])),
        .zero     (zero),
        .halt     (halt_q),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .ld_ac    (ld_ac),
        .data_e   (data_e),
        .ld_ir    (ld_ir),
        .inc_pc   (inc_pc),
        .ld_pc    (ld_pc),
        .set_halt (set_halt)
    );

    always_comb begin
        phase_d = halt_q ? phase_q : phase_t'(phase_q + 3'd1);
        pc_d    = ld_pc ? ir_q[AW-1:0] : inc_pc ? pc_q + AW'(1) : pc_q;
        ir_d    = ld_ir ? mem_data_out : ir_q;
        halt_d  = halt_q || set_halt;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            phase_q <= INST_ADDR;
            pc_q    <= '0;
            ir_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            halt_q  <= halt_d;
        end
    end

    assign mem_addr = phase_q < OP_ADDR ? pc_q : ir_q[AW-1:0];
    assign opcode   = ir_q[DW-1:DW-3];
    assign pc       = pc_q;
    assign halt     = halt_q;
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/execute sequencer for the VeriRISC CPU. Owns the program counter, instruction register and the 8-phase instruction cycle. Drives address and read/write strobes into the synchronous 32x8 memory directly downstream, and captures that memory's registered read data as instructions. Also emits the accumulator/ALU control strobes.

## Interface
Parameters:
- AW, 5, address width (memory depth 2**AW = 32)
- DW, 8, data/instruction width; opcode = DW-1:DW-3, operand = AW-1:0

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_  in  1  reset, synchronous and active-low (one clock, `clk`; sampled on posedge only)
- mem_data_out  in  DW  registered read data from memory
- zero  in  1  accumulator-is-zero flag
- mem_addr  out  AW  memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ld_ac  out  1  accumulator load enable
- data_e  out  1  accumulator-to-memory data bus enable
- opcode  out  3  current IR opcode, to ALU
- pc  out  AW  current program counter
- halt  out  1  sticky halted flag

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- 3-bit phase counter advances every clock, 7 wraps to 0: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7).
- mem_addr = pc in phases 0–3; IR operand in phases 4–7.
- Outputs are decoded combinationally from the registered phase, IR and `zero`. There are no other inputs in the decode path.
- Per-phase outputs:
  - mem_read = 1 in phases 1,2,3, and in phases 5,6,7 when ALUOP.
  - IR loads from mem_data_out at end of phase 2 (ld_ir internal, also high in phase 3; second load is idempotent).
  - PC increment at end of phase 4 unless HLT.
  - SKZ with zero=1: extra PC increment at end of phase 6.
  - JMP: PC loads operand at end of phases 6 and 7.
  - STO: data_e = 1 in phases 6,7; mem_write = 1 in phase 7.
  - ALUOP: ld_ac = 1 in phase 7.
  - HLT: halt set at end of phase 4. While halt=1, phase, PC and IR freeze and all strobes are 0. Only reset clears halt.
- mem_read and mem_write are never both 1; a bench assertion checks this.
- PC arithmetic is modulo 2**AW: 31+1 wraps to 0.

## Timing
- Reset, when rst_=0 at a posedge: phase=0, pc=0, ir=0, halt=0.
  - Resulting outputs: mem_addr=0, mem_read=0, mem_write=0, ld_ac=0, data_e=0, opcode=0.
  - Reset mid-instruction aborts it; no partial write occurs after the reset edge.
- Every instruction takes exactly 8 clocks. Instruction n+1 begins phase 0 on cycle 8(n+1) after reset release.
- Memory read latency is 1 clock. Data strobed in phase 1 is valid in phase 2 and captured at the phase-2 edge.
- Operand data strobed in phase 5 is valid in phases 6–7 for the ALU.
- The write in phase 7 is committed by memory at the phase-7 edge.
- A JMP target takes effect at the next phase 0.

## Structure
- Shared package `cpu_pkg`:
  - `opcode_t` enum (HLT..JMP)
  - `phase_t` enum (INST_ADDR..STORE)
  - AW/DW defaults
- One sub-module, `ctl_decode`: purely combinational map from (phase, opcode, zero, halt) to strobe set.
- The top holds the phase counter, PC, IR and halt registers.

## Test plan
- Reset check: hold rst_=0 for 2 clocks with memory filled with 0xFF.
  - During reset: all strobes 0, mem_addr=0, pc=0, halt=0.
  - After release: phase 1 shows mem_read=1 at addr 0.
- LDA: mem[0]=0xB4 (LDA 0x14).
  - opcode=5 from phase 3.
  - mem_addr=0x14 in phases 4–7.
  - mem_read=1 in phases 5–7; ld_ac=1 only in phase 7.
  - pc=1 at next phase 0.
- SKZ: mem[0]=0x20.
  - zero=1 → pc=2 at next phase 0.
  - zero=0 → pc=1.
- JMP and STO:
  - mem[0]=0xFA (JMP 0x1A) → pc=0x1A at next phase 0.
  - mem[0x1A]=0xC3 (STO 0x03) → data_e=1 in phases 6–7, mem_write=1 in phase 7 only, addr=3.
- HLT and wrap-around:
  - Program with JMP 0x1F, where mem[0x1F] is an ADD → pc wraps to 0.
  - mem[0]=0x00 → halt=1 after phase 4; pc, phase and strobes frozen for 20 clocks.
  - rst_=0 clears halt.
- Reset mid-operation: assert rst_=0 at phase 6 of STO → mem_write never asserts and pc returns to 0.
